// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the parametrised register file.
//   - state_e   : clear-sequencer state encoding (READY=0, CLEAR=1; no idle state)
//   - MIN_RD/MAX_RD, num_rd_ok() : legal range for the number of read ports
//   - RF_SLICE  : slice helper for packed multi-port buses

`ifndef REGFILE_PKG_MACROS
`define REGFILE_PKG_MACROS
// Port idx of a packed bus whose ports are w bits wide.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package regfile_pkg;

    typedef enum logic {
        StReady = 1'b0,
        StClear = 1'b1
    } state_e;

    localparam int unsigned MIN_RD = 1;
    localparam int unsigned MAX_RD = 4;

    function automatic bit num_rd_ok(int unsigned n);
        return (n >= MIN_RD) && (n <= MAX_RD);
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear sequencer and storage write-port mux.
//   After reset or a clr_req in READY it sweeps every entry to zero, one per
//   cycle, and reports busy. Writes arriving mid-sweep are dropped and flagged.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   clr_req                : start a sweep (honoured in READY only)
//   wr_en/wr_addr/wr_data  : writeback port from the core
//   busy                   : sweep in progress
//   wr_drop                : sticky, a write was dropped during a sweep
//   mem_we/mem_waddr/mem_wdata : resolved storage write port

module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_drop,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              wr_drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    if (wr_en) begin
                        wr_drop_q <= 1'b1;
                    end
                    ptr_q <= ptr_q + 1'b1;
                    // Explicit compare on the last entry rather than relying on wrap.
                    if (ptr_q == LAST) begin
                        state_q <= StReady;
                    end
                end
                StReady: begin
                    if (clr_req) begin
                        state_q   <= StClear;
                        ptr_q     <= '0;
                        wr_drop_q <= 1'b0;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    assign busy    = (state_q == StClear);
    assign wr_drop = wr_drop_q;

    // Sweep owns the write port while busy; a write in the clr_req cycle still
    // lands (READY) and is then zeroed by the sweep. Nothing is written under rst.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!rst) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
            end else if (wr_en && !(ZERO_REG && (wr_addr == '0))) begin
                mem_we = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: single-write, multi-read register file with clear sequencer.
//   Storage has no per-entry reset (maps to distributed RAM); it is zeroed by
//   regfile_clr_seq. Read ports are combinational with optional write bypass;
//   entry 0 can be hardwired to zero. All reads return 0 while busy.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rd_addr/rd_data   : NUM_RD packed read ports (port i at slice i)
//   wr_en/wr_addr/wr_data : write port
//   dbg_addr/dbg_data : debug read port, zero rule but never bypassed
//   clr_req           : request a clear sweep
//   busy, wr_drop     : sweep running / write dropped during sweep (sticky)

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (!num_rd_ok(NUM_RD)) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    regfile_clr_seq #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .wr_drop  (wr_drop),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;

        assign ra = `RF_SLICE(rd_addr, i, ADDR_W);

        // Bypass only in READY; wr_en is ignored while the sweep runs.
        always_comb begin
            if (busy) begin
                rdat = '0;
            end else if (ZERO_REG && (ra == '0)) begin
                rdat = '0;
            end else if (BYPASS && wr_en && (wr_addr == ra)) begin
                rdat = wr_data;
            end else begin
                rdat = mem[ra];
            end
        end

        assign `RF_SLICE(rd_data, i, DATA_W) = rdat;
    end

    always_comb begin
        if (busy) begin
            dbg_data = '0;
        end else if (ZERO_REG && (dbg_addr == '0)) begin
            dbg_data = '0;
        end else begin
            dbg_data = mem[dbg_addr];
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the single-write, two-read register file used by the mips32 core.
- Configurable data width, depth and number of combinational read ports; optional same-cycle write-to-read bypass; hardwired zero register.
- Storage is a plain array with no per-entry reset, so it maps to distributed RAM. A sequential clear sequencer zeroes it after reset or on request, one entry per cycle, and flags `busy` meanwhile.
- Sits between decode (read ports) and writeback (write port).
- A dedicated debug read port lets benches inspect architectural state without disturbing the core's read ports.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1 entry 0 is read-only and always reads 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data; combinational; never bypassed.
- clr_req  in  1  request a full clear sweep (level-sampled, READY state only).
- busy  out  1  high while the clear sweep runs.
- wr_drop  out  1  sticky: a write arrived while busy; cleared by rst or by a new sweep start.

Behaviour:
- Reset (rst high at a rising edge):
  - state <= CLEAR, ptr <= 0, wr_drop <= 0.
  - busy is high from the first cycle after that edge.
  - Storage contents are not reset directly; the sweep clears them.
- State CLEAR:
  - Each cycle: mem[ptr] <= 0, ptr <= ptr+1.
  - On the cycle ptr == DEPTH-1, write that entry and go to READY.
  - Sweep length is exactly DEPTH cycles: busy is high for DEPTH cycles after reset deasserts.
  - wr_en is ignored; if wr_en is high, wr_drop <= 1.
  - All rd_data and dbg_data read 0. No bypass.
- State READY:
  - If wr_en and not (ZERO_REG and wr_addr==0): mem[wr_addr] <= wr_data at the rising edge.
  - If clr_req: go to CLEAR, ptr <= 0, wr_drop <= 0. A write in that same cycle is still committed, then gets cleared by the sweep.
  - clr_req during CLEAR has no effect; the sweep is not restarted.
- Reads (READY), per port i, combinational:
  - If ZERO_REG and rd_addr[i]==0, output 0.
  - Else if BYPASS and wr_en and wr_addr==rd_addr[i], output wr_data.
  - Else output mem[rd_addr[i]].
- BYPASS=0: a read returns the old value in the write cycle and the new value from the next cycle.
- Multiple read ports with the same address return identical data.
- dbg_data follows the zero rule but never bypasses.
- rst asserted mid-sweep restarts the sweep from ptr 0.
- Write-after-write to the same address in consecutive cycles: the last write wins.
- ptr is ADDR_W bits. Termination is detected by compare against DEPTH-1, not by wrap-around.

Decomposition:
- Shared package regfile_pkg:
  - State encoding: IDLE unused, CLEAR=1'b1, READY=1'b0.
  - NUM_RD bounds check constant.
  - Slice helper macros for packed ports.
- One natural sub-module: regfile_clr_seq, holding the state register, ptr counter, busy, wr_drop and the storage write-enable mux.
- The top holds the storage array, the read muxes and the bypass logic.

Test Plan:
- Clear after reset: pulse rst for 2 cycles, release -> busy high for exactly 32 cycles, then 0; dbg_data reads 0 for addresses 0..31.
- Core program equivalent: write r8=2, r9=3, r10=5 on three consecutive READY cycles -> dbg_addr 8/9/10 read 2/3/5 one cycle after each write.
- Bypass: BYPASS=1, wr_en with wr_addr=9, wr_data=0xDEADBEEF and rd_addr port0=9 in the same cycle -> rd_data port0 = 0xDEADBEEF that cycle. With BYPASS=0 -> the old value 3, then 0xDEADBEEF the next cycle.
- Zero register: write r0=0x1234 -> all ports and dbg read 0 at address 0. With ZERO_REG=0 -> read 0x1234.
- Write during sweep: assert clr_req with r5=7 stored, then wr_en r6=9 two cycles later -> wr_drop=1; after the sweep, r5=0 and r6=0.
- Mid-sweep reset and parametrics: assert rst at sweep cycle 10 -> busy stays high for another full 32 cycles. Repeat with ADDR_W=3, NUM_RD=4, DATA_W=16 -> busy lasts 8 cycles; 4 ports reading addresses 1,2,1,7 return matching data.
